// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU memory port:
// word width, state codes and address helpers.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        DONE   = ST_DONE
    } state_t;

    function automatic logic word_aligned(
        input logic [WORD_W-1:0] a
    );
        return a[1:0] == 2'b00;
    endfunction

    function automatic logic [WORD_W-1:0] word_addr(
        input logic [WORD_W-1:0] a
    );
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Bundle between the control FSM, the memory port sequencer
// and the word-addressed memory.
interface mem_port_ctrl_if;
    import cpu_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata_out;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        input  mem_ack,
        input  mem_rdata,
        output rdata_out,
        output busy,
        output done,
        output err,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        output mem_ack,
        output mem_rdata,
        input  rdata_out,
        input  busy,
        input  done,
        input  err,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/holding_reg.sv
// Generic load-enabled holding register with asynchronous
// active-high clear.
module holding_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory port sequencer: one read or write per request,
// read data held in the memory data register.
module mem_port_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input logic           clk,
    input logic           reset,
    mem_port_ctrl_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic              err_q;
    logic              err_nx;
    logic              we_q;
    logic              bad_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              take;
    logic              load;
    logic              rst_hr;

    assign take = (state == IDLE) && bus.req;

    // Misaligned requests spend one silent ACCESS cycle so that
    // error and success completions share the same done latency.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    state_nx = ACCESS;
                    cnt_nx   = '0;
                end
            end
            ACCESS: begin
                if (bad_q) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else if (bus.mem_ack) begin
                    state_nx = DONE;
                end else if (cnt == LAST) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            we_q    <= bus.we;
            bad_q   <= !word_aligned(bus.addr);
            addr_q  <= word_addr(bus.addr);
            wdata_q <= bus.wdata;
        end
    end

    assign load = (state == ACCESS) && bus.mem_ack
                  && !we_q && !bad_q;
    assign rst_hr = ~reset;

    holding_reg #(
        .W (WORD_W)
    ) u_mdr (
        .clk (clk),
        .rst (rst_hr),
        .en  (load),
        .d   (bus.mem_rdata),
        .q   (bus.rdata_out)
    );

    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.err       = err_q;
    assign bus.mem_req   = (state == ACCESS) && !bad_q;
    assign bus.mem_we    = bus.mem_req && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: transaction-level model
// compared every cycle plus directed literal checks.
module tb_mem_port_ctrl;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    mem_port_ctrl_if bus();

    mem_port_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Model: phase 0 idle, 1 access, 2 done
    int          ph = 0;
    int          waited = 0;
    bit          e_err = 0;
    bit          m_bad = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = 0;
    logic [31:0] m_wdata = 0;
    logic [31:0] m_rdata = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph = 0; waited = 0; e_err = 0; m_bad = 0;
            m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        end else begin
            case (ph)
                0: if (bus.req) begin
                    m_we    = bus.we;
                    m_addr  = bus.addr & 32'hFFFF_FFFC;
                    m_wdata = bus.wdata;
                    m_bad   = (bus.addr % 4) != 0;
                    waited  = 0;
                    ph      = 1;
                end
                1: begin
                    waited++;
                    if (m_bad) begin
                        ph = 2; e_err = 1;
                    end else if (bus.mem_ack) begin
                        if (!m_we) m_rdata = bus.mem_rdata;
                        ph = 2; e_err = 0;
                    end else if (waited == TIMEOUT) begin
                        ph = 2; e_err = 1;
                    end
                end
                default: ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(ph != 0));
        check("done", 32'(bus.done), 32'(ph == 2));
        check("err", 32'(bus.err), 32'(ph == 2 && e_err));
        check("mem_req", 32'(bus.mem_req),
              32'(ph == 1 && !m_bad));
        check("mem_we", 32'(bus.mem_we),
              32'(ph == 1 && !m_bad && m_we));
        check("rdata_out", bus.rdata_out, m_rdata);
        if (ph == 1 && !m_bad) begin
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_wdata", bus.mem_wdata, m_wdata);
        end
    end

    int          n_done = 0;
    int          n_req = 0;
    int          n_acc = 0;
    bit          prev_req = 0;
    logic [31:0] last_addr = 0;
    logic [31:0] last_wdata = 0;
    bit          last_we = 0;

    always @(negedge clk) begin
        if (bus.done) n_done++;
        if (bus.mem_req) begin
            n_req++;
            last_addr  = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            last_we    = bus.mem_we;
        end
        if (bus.mem_req && !prev_req) n_acc++;
        prev_req = bus.mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_done = 0;
        n_req  = 0;
        n_acc  = 0;
    endtask

    task automatic wait_done(input int budget, output logic got);
        int n = 0;
        got = 1'b0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done=0 after %0d cycles, expected 1",
                     budget);
        end else begin
            got = bus.err;
        end
    endtask

    task automatic do_access(input logic w,
                             input logic [31:0] a,
                             input logic [31:0] wd,
                             input int ack_at,
                             input logic [31:0] rd,
                             output logic got_err);
        bus.req = 1'b1;
        bus.we = w;
        bus.addr = a;
        bus.wdata = wd;
        tick();
        bus.req = 1'b0;
        if (ack_at > 0) begin
            repeat (ack_at - 1) tick();
            bus.mem_ack = 1'b1;
            bus.mem_rdata = rd;
            tick();
            bus.mem_ack = 1'b0;
            bus.mem_rdata = '0;
        end
        wait_done(40, got_err);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic e;
        bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rdata", bus.rdata_out, 0);
        #2 reset = 1'b1;
        tick();

        clr();
        do_access(0, 32'h100, 0, 1, 32'hDEADBEEF, e);
        check("rd_err", 32'(e), 0);
        check("rd_done_cnt", n_done, 1);
        check("rd_req_cycles", n_req, 1);
        check("rd_addr", last_addr, 32'h100);
        check("rd_data", bus.rdata_out, 32'hDEADBEEF);

        clr();
        do_access(1, 32'h2C, 32'hAFAFAFAF, 4, 32'h11111111, e);
        check("wr_err", 32'(e), 0);
        check("wr_req_cycles", n_req, 4);
        check("wr_we", 32'(last_we), 1);
        check("wr_wdata", last_wdata, 32'hAFAFAFAF);
        check("wr_addr", last_addr, 32'h2C);
        check("wr_rdata_kept", bus.rdata_out, 32'hDEADBEEF);
        check("wr_done_cnt", n_done, 1);

        clr();
        do_access(0, 32'h200, 0, 0, 0, e);
        check("to_err", 32'(e), 1);
        check("to_req_cycles", n_req, 16);
        check("to_rdata_kept", bus.rdata_out, 32'hDEADBEEF);
        check("to_done_cnt", n_done, 1);

        clr();
        do_access(0, 32'h204, 0, 16, 32'h5A5A5A5A, e);
        check("to16_err", 32'(e), 0);
        check("to16_req_cycles", n_req, 16);
        check("to16_rdata", bus.rdata_out, 32'h5A5A5A5A);

        clr();
        bus.req = 1; bus.we = 0; bus.addr = 32'h102;
        tick();
        bus.req = 0;
        check("mis_done_early", 32'(bus.done), 0);
        check("mis_req_early", 32'(bus.mem_req), 0);
        tick();
        check("mis_done", 32'(bus.done), 1);
        check("mis_err", 32'(bus.err), 1);
        tick();
        check("mis_req_cycles", n_req, 0);
        check("mis_done_cnt", n_done, 1);
        check("mis_rdata_kept", bus.rdata_out, 32'h5A5A5A5A);

        clr();
        bus.req = 1; bus.we = 0; bus.addr = 32'h300;
        tick();
        bus.req = 0;
        tick();
        check("mid_req_before", 32'(bus.mem_req), 1);
        #1 reset = 1'b0;
        #1;
        check("mid_req_drop", 32'(bus.mem_req), 0);
        check("mid_busy", 32'(bus.busy), 0);
        check("mid_rdata", bus.rdata_out, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        tick();
        check("mid_no_done", n_done, 0);

        clr();
        do_access(0, 32'h0, 0, 2, 32'h12345678, e);
        check("post_err", 32'(e), 0);
        check("post_rdata", bus.rdata_out, 32'h12345678);
        check("post_done_cnt", n_done, 1);

        clr();
        bus.req = 1; bus.we = 0; bus.addr = 32'h40;
        tick();
        bus.addr = 32'h80;
        tick();
        bus.req = 0;
        bus.mem_ack = 1; bus.mem_rdata = 32'h0BADF00D;
        tick();
        bus.req = 1; bus.addr = 32'h84;
        bus.mem_rdata = 32'hFFFFFFFF;
        tick();
        bus.req = 0;
        tick();
        bus.mem_ack = 0; bus.mem_rdata = 0;
        tick();
        tick();
        check("bp_accesses", n_acc, 1);
        check("bp_done_cnt", n_done, 1);
        check("bp_addr", last_addr, 32'h40);
        check("bp_rdata", bus.rdata_out, 32'h0BADF00D);
        check("bp_idle", 32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
